// File: rtl/reg_file_access_ctrl.sv
// ---------------------------------------------------------------------------
// reg_file_access_ctrl
//
// Debug/test-host access sequencer for the CPU register file. It accepts
// single READ/WRITE commands and two bulk operations (DUMP, CLEAR) on a
// valid/ready command channel. It drives the register file's write port and
// read port 1, and returns one or more results on a valid/ready response
// channel.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   cmd_valid/ready     command handshake; cmd_ready is high only in IDLE
//   cmd_op              00 READ, 01 WRITE, 10 DUMP, 11 CLEAR
//   cmd_addr, cmd_data  target register and write data
//   rsp_valid/ready     response handshake
//   rsp_addr/data/last  registered response fields, stable until handshake
//   busy                high whenever the sequencer is not in IDLE
//   rf_wen/waddr/wdata  register-file write port
//   rf_raddr, rf_rdata  register-file read port (rf_rdata is combinational)
// ---------------------------------------------------------------------------
module reg_file_access_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int REG_NUM    = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // command channel
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  // response channel
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ADDR_WIDTH-1:0] rsp_addr,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_last,
  output logic                  busy,
  // register-file ports
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic [ADDR_WIDTH-1:0] rf_raddr,
  input  logic [DATA_WIDTH-1:0] rf_rdata
);

  // FSM encoding
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WR   = 3'd1;
  localparam logic [2:0] ST_RD   = 3'd2;
  localparam logic [2:0] ST_CLR  = 3'd3;
  localparam logic [2:0] ST_RESP = 3'd4;

  // Command opcodes
  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_DUMP  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  // Bulk operations stop on this index, so the counter never wraps.
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(REG_NUM - 1);
  localparam logic [ADDR_WIDTH-1:0] IDX_ONE   = ADDR_WIDTH'(1);
  // CLEAR reports how many registers it wrote (all but register 0).
  localparam logic [DATA_WIDTH-1:0] CLR_COUNT = DATA_WIDTH'(REG_NUM - 1);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [2:0]            state_q,    state_d;
  logic [1:0]            op_q,       op_d;
  logic [ADDR_WIDTH-1:0] addr_q,     addr_d;
  logic [DATA_WIDTH-1:0] data_q,     data_d;
  logic [ADDR_WIDTH-1:0] index_q,    index_d;
  logic [ADDR_WIDTH-1:0] rsp_addr_q, rsp_addr_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  rsp_last_q, rsp_last_d;

  // Last driven register-file addresses/data; idle ports hold these values.
  logic [ADDR_WIDTH-1:0] rf_waddr_q;
  logic [DATA_WIDTH-1:0] rf_wdata_q;
  logic [ADDR_WIDTH-1:0] rf_raddr_q;

  logic                  cmd_fire;
  logic                  rsp_fire;
  logic [ADDR_WIDTH-1:0] rd_sel_addr;

  assign cmd_fire    = cmd_valid && cmd_ready;
  assign rsp_fire    = rsp_valid && rsp_ready;
  // READ targets the latched address, DUMP walks the index.
  assign rd_sel_addr = (op_q == OP_DUMP) ? index_q : addr_q;

  // -------------------------------------------------------------------------
  // Handshake and status outputs
  // -------------------------------------------------------------------------
  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_addr  = rsp_addr_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_last  = rsp_last_q;

  // -------------------------------------------------------------------------
  // Register-file port drive
  // -------------------------------------------------------------------------
  // rf_wen is purely combinational from the state so that an asynchronous
  // reset removes it in the same instant, leaving a partial CLEAR untouched.
  always_comb begin
    // NOTE: every output gets a default before the case, otherwise states
    // that do not mention a signal would infer a latch.
    rf_wen   = 1'b0;
    rf_waddr = rf_waddr_q;
    rf_wdata = rf_wdata_q;
    rf_raddr = rf_raddr_q;
    case (state_q)
      ST_WR: begin
        // Register 0 is hard-wired; the write is suppressed but still answered.
        rf_wen   = (addr_q != '0);
        rf_waddr = addr_q;
        rf_wdata = data_q;
      end
      ST_RD: begin
        rf_raddr = rd_sel_addr;
      end
      ST_CLR: begin
        rf_wen   = 1'b1;
        rf_waddr = index_q;
        rf_wdata = '0;
      end
      default: ;
    endcase
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    data_d     = data_q;
    index_d    = index_q;
    rsp_addr_d = rsp_addr_q;
    rsp_data_d = rsp_data_q;
    rsp_last_d = rsp_last_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_fire) begin
          op_d   = cmd_op;
          addr_d = cmd_addr;
          data_d = cmd_data;
          case (cmd_op)
            OP_READ:  state_d = ST_RD;
            OP_WRITE: state_d = ST_WR;
            OP_DUMP: begin
              state_d = ST_RD;
              index_d = '0;
            end
            default: begin // OP_CLEAR
              state_d = ST_CLR;
              index_d = IDX_ONE;
            end
          endcase
        end
      end

      ST_WR: begin
        rsp_addr_d = addr_q;
        rsp_data_d = (addr_q == '0) ? '0 : data_q;
        rsp_last_d = 1'b1;
        state_d    = ST_RESP;
      end

      ST_RD: begin
        rsp_addr_d = rd_sel_addr;
        rsp_data_d = rf_rdata;
        rsp_last_d = (op_q != OP_DUMP) || (index_q == LAST_IDX);
        state_d    = ST_RESP;
      end

      ST_CLR: begin
        if (index_q == LAST_IDX) begin
          rsp_addr_d = LAST_IDX;
          rsp_data_d = CLR_COUNT;
          rsp_last_d = 1'b1;
          state_d    = ST_RESP;
        end else begin
          index_d = index_q + IDX_ONE;
        end
      end

      ST_RESP: begin
        if (rsp_fire) begin
          if (rsp_last_q) begin
            state_d = ST_IDLE;
          end else begin
            // Only a DUMP produces non-final responses.
            index_d = index_q + IDX_ONE;
            state_d = ST_RD;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Sequential state
  // -------------------------------------------------------------------------
  // NOTE: every register here has a reset value; there is no storage array
  // in this block, so nothing is left uninitialised.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_READ;
      addr_q     <= '0;
      data_q     <= '0;
      index_q    <= '0;
      rsp_addr_q <= '0;
      rsp_data_q <= '0;
      rsp_last_q <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      rf_raddr_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q    <= state_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      index_q    <= index_d;
      rsp_addr_q <= rsp_addr_d;
      rsp_data_q <= rsp_data_d;
      rsp_last_q <= rsp_last_d;
      rf_waddr_q <= rf_waddr;
      rf_wdata_q <= rf_wdata;
      rf_raddr_q <= rf_raddr;
    end
  end

endmodule
